ahb_slave_mem: RTL

- AHB-Lite completer with a small word-organised register memory.
- Responds to the transfers driven into the bridge test environment and serves as the golden AHB-side responder.
- Supports configurable wait states, byte/halfword/word accesses, and two-cycle ERROR responses for illegal accesses.
- Sits on the same AHB signal set as the bridge's AHB port; hburst is accepted but not interpreted.

---
 rtl/ahb_slv_pkg.sv | 10 +
 rtl/ahb_slave_mem_if.sv | 15 +
 rtl/ahb_slv_decode.sv | 18 +
 rtl/ahb_slave_mem.sv | 105 ++++++++++
 4 files changed

// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg: shared AHB-Lite encodings and the byte-lane helper for ahb_slave_mem
package ahb_slv_pkg;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_e;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_ERROR} hresp_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} slv_state_e;
  function automatic logic [3:0] byte_lane_mask(input logic [2:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite bus bundle; master drives address/control/wdata/hready_in, slave drives hready_out/hresp/hrdata
interface ahb_slave_mem_if;
  logic [31:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize;
  logic [2:0] hburst;
  logic [31:0] hwdata;
  logic hready_in;
  logic hready_out;
  logic [1:0] hresp;
  logic [31:0] hrdata;
  modport slave (input haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in, output hready_out, hresp, hrdata);
  modport master (output haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in, input hready_out, hresp, hrdata);
endinterface

// File: rtl/ahb_slv_decode.sv
// ahb_slv_decode: address-phase legality (range, size, alignment) and little-endian byte-lane mask
// in: haddr, hsize; out: legal, mask
module ahb_slv_decode import ahb_slv_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH = 16
) (
  input logic [31:0] haddr,
  input logic [2:0] hsize,
  output logic legal,
  output logic [3:0] mask
);
  logic [31:0] off;
  logic aligned;
  assign off = haddr - BASE_ADDR;
  assign aligned = hsize == SZ_HALF ? !haddr[0] : hsize == SZ_WORD ? haddr[1:0] == 2'b00 : 1'b1;
  assign legal = off < 32'(DEPTH * 4) && hsize <= 3'd2 && aligned;
  assign mask = byte_lane_mask(hsize, haddr[1:0]);
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite completer with a word-organised register memory, wait states and two-cycle ERROR
// ports: clock, hresetn (async active-low), bus (ahb_slave_mem_if.slave), prot_err (only with AHB_SLV_PROT_CHK_EN)
// AHB_SLV_PROT_CHK_EN: flags SEQ transfers that do not continue the previous NONSEQ/SEQ and answers them with ERROR
module ahb_slave_mem import ahb_slv_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH = 16,
  parameter int WAIT_STATES = 0
) (
  input logic clock,
  input logic hresetn,
  ahb_slave_mem_if.slave bus
`ifdef AHB_SLV_PROT_CHK_EN
  , output logic prot_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  slv_state_e state;
  logic [2:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] addr_q, off_q;
  logic [2:0] size_q;
  logic [3:0] mask_q, mask;
  logic write_q, dp_q, dec_legal, legal, accept, perr;
  logic [AW-1:0] idx;
  logic unused_ok;
  ahb_slv_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_dec (
    .haddr(bus.haddr),
    .hsize(bus.hsize),
    .legal(dec_legal),
    .mask(mask)
  );
  // the slave only samples while it is itself ready, so wait/ERR1 cycles never take a new address
  assign accept = bus.hready_in && bus.hready_out && bus.htrans[1];
`ifdef AHB_SLV_PROT_CHK_EN
  logic prev_ok_q;
  assign perr = bus.htrans == TR_SEQ && (!prev_ok_q || bus.haddr != addr_q + (32'd1 << size_q));
  always_ff @(posedge clock or negedge hresetn)
    if (!hresetn) begin
      prev_ok_q <= 1'b0;
      prot_err <= 1'b0;
    end else if (bus.hready_in && bus.hready_out) begin
      prev_ok_q <= bus.htrans[1];
      if (accept && perr) prot_err <= 1'b1;
    end
`else
  assign perr = 1'b0;
`endif
  assign legal = dec_legal && !perr;
  assign off_q = addr_q - BASE_ADDR;
  assign idx = off_q[AW+1:2];
  assign bus.hrdata = dp_q && !write_q ? mem[idx] : 32'h0;
  assign unused_ok = ^{bus.hburst, off_q, size_q};
  always_ff @(posedge clock or negedge hresetn)
    if (!hresetn) begin
      state <= ST_IDLE;
      cnt <= 3'd0;
      bus.hready_out <= 1'b1;
      bus.hresp <= RESP_OKAY;
      addr_q <= 32'h0;
      size_q <= 3'd0;
      write_q <= 1'b0;
      mask_q <= 4'h0;
      dp_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      if (dp_q && write_q && bus.hready_out)
        for (int i = 0; i < 4; i++)
          if (mask_q[i]) mem[idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      if (bus.hready_out) dp_q <= accept && legal;
      if (accept) begin
        addr_q <= bus.haddr;
        size_q <= bus.hsize;
        write_q <= bus.hwrite;
        mask_q <= mask;
      end
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            state <= ST_IDLE;
            bus.hready_out <= 1'b1;
          end
        end
        ST_ERR1: begin
          state <= ST_ERR2;
          bus.hready_out <= 1'b1;
        end
        default:
          if (accept && !legal) begin
            state <= ST_ERR1;
            bus.hready_out <= 1'b0;
            bus.hresp <= RESP_ERROR;
          end else if (accept && WAIT_STATES != 0) begin
            state <= ST_WAIT;
            cnt <= 3'(WAIT_STATES - 1);
            bus.hready_out <= 1'b0;
            bus.hresp <= RESP_OKAY;
          end else begin
            state <= ST_IDLE;
            bus.hready_out <= 1'b1;
            bus.hresp <= RESP_OKAY;
          end
      endcase
    end
endmodule
